// File: rtl/intr_pkg.sv
// Shared definitions for the interrupt arbiter: FSM state encoding,
// interrupt class codes and default sizing.
package intr_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_F_REQ = 3'd1,
        ST_F_ACK = 3'd2,
        ST_F_SVC = 3'd3,
        ST_N_REQ = 3'd4,
        ST_N_ACK = 3'd5,
        ST_N_SVC = 3'd6
    } state_t;

    localparam logic CLS_FAST = 1'b1;
    localparam logic CLS_NORM = 1'b0;

    localparam int N_IO_DEF = 4;
    localparam int IDW_DEF  = 4;

endpackage

// File: rtl/intr_arbiter_rr_pick.sv
// Combinational round-robin selector: lowest set request at or after ptr,
// wrapping modulo N_IO.
module rr_pick
    import intr_pkg::*;
#(
    parameter int N_IO = N_IO_DEF,
    parameter int IDW  = IDW_DEF
) (
    input  logic [N_IO-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic            any,
    output logic [IDW-1:0]  idx
);

    localparam logic [IDW:0] N_L = (IDW+1)'(N_IO);

    logic [N_IO-1:0] w_rot;
    logic [IDW-1:0]  w_off;
    logic [IDW:0]    w_sum;

    // Rotating the doubled vector puts the pointer position at bit 0.
    assign w_rot = N_IO'({req, req} >> ptr);

    always_comb begin
        w_off = '0;
        for (int k = N_IO - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_off = IDW'(k);
            end
        end
    end

    assign w_sum = {1'b0, ptr} + {1'b0, w_off};
    assign idx   = (w_sum >= N_L) ? IDW'(w_sum - N_L) : w_sum[IDW-1:0];
    assign any   = |req;

endmodule

// File: rtl/intr_arbiter.sv
// Shares the CPU fast/normal interrupt lines among N_IO modules with
// per-class round-robin and one level of fast-over-normal preemption.
module intr_arbiter
    import intr_pkg::*;
#(
    parameter int N_IO = N_IO_DEF,
    parameter int IDW  = IDW_DEF
) (
    input  logic            Clk,
    input  logic            Reset_,
    input  logic [N_IO-1:0] fintr_req,
    input  logic [N_IO-1:0] intr_req,
    input  logic            cpu_ack,
    input  logic            isr_done,
    output logic            fintr,
    output logic            intr,
    output logic [N_IO-1:0] int_ack,
    output logic [N_IO-1:0] Enable,
    output logic [IDW:0]    vector,
    output logic            busy
);

    state_t          r_state;
    logic            r_nested;
    logic [IDW-1:0]  r_fptr, r_nptr, r_fowner, r_nowner;
    logic            r_fintr, r_intr, r_busy;
    logic [N_IO-1:0] r_int_ack, r_enable;
    logic [IDW:0]    r_vector;

    logic            w_fany, w_nany;
    logic [IDW-1:0]  w_fidx, w_nidx;

    rr_pick #(.N_IO(N_IO), .IDW(IDW)) u_fpick (
        .req (fintr_req), .ptr (r_fptr), .any (w_fany), .idx (w_fidx)
    );

    rr_pick #(.N_IO(N_IO), .IDW(IDW)) u_npick (
        .req (intr_req), .ptr (r_nptr), .any (w_nany), .idx (w_nidx)
    );

    function automatic logic [N_IO-1:0] f_onehot(input logic [IDW-1:0] i);
        return N_IO'(1) << i;
    endfunction

    function automatic logic [IDW-1:0] f_next(input logic [IDW-1:0] i);
        return (i == IDW'(N_IO - 1)) ? '0 : i + 1'b1;
    endfunction

    // Outputs are registered and written on the transition into each state.
    always_ff @(posedge Clk or negedge Reset_) begin
        if (!Reset_) begin
            r_state   <= ST_IDLE;
            r_nested  <= 1'b0;
            r_fptr    <= '0;
            r_nptr    <= '0;
            r_fowner  <= '0;
            r_nowner  <= '0;
            r_fintr   <= 1'b0;
            r_intr    <= 1'b0;
            r_busy    <= 1'b0;
            r_int_ack <= '0;
            r_enable  <= '0;
            r_vector  <= '0;
        end else begin
            r_int_ack <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (w_fany) begin
                        r_fowner <= w_fidx;
                        r_fintr  <= 1'b1;
                        r_state  <= ST_F_REQ;
                    end else if (w_nany) begin
                        r_nowner <= w_nidx;
                        r_intr   <= 1'b1;
                        r_state  <= ST_N_REQ;
                    end
                end
                ST_F_REQ: begin
                    if (cpu_ack) begin
                        r_fintr   <= 1'b0;
                        r_int_ack <= f_onehot(r_fowner);
                        r_enable  <= f_onehot(r_fowner);
                        r_vector  <= {CLS_FAST, r_fowner};
                        r_busy    <= 1'b1;
                        r_state   <= ST_F_ACK;
                    end
                end
                ST_F_ACK: begin
                    r_fptr  <= f_next(r_fowner);
                    r_state <= ST_F_SVC;
                end
                ST_F_SVC: begin
                    if (isr_done) begin
                        if (r_nested) begin
                            r_nested <= 1'b0;
                            r_enable <= f_onehot(r_nowner);
                            r_vector <= {CLS_NORM, r_nowner};
                            r_state  <= ST_N_SVC;
                        end else begin
                            r_enable <= '0;
                            r_vector <= '0;
                            r_busy   <= 1'b0;
                            r_state  <= ST_IDLE;
                        end
                    end
                end
                ST_N_REQ: begin
                    if (cpu_ack) begin
                        r_intr    <= 1'b0;
                        r_int_ack <= f_onehot(r_nowner);
                        r_enable  <= f_onehot(r_nowner);
                        r_vector  <= {CLS_NORM, r_nowner};
                        r_busy    <= 1'b1;
                        r_state   <= ST_N_ACK;
                    end else if (w_fany) begin
                        // Abandoned normal request is re-arbitrated later.
                        r_intr   <= 1'b0;
                        r_fintr  <= 1'b1;
                        r_fowner <= w_fidx;
                        r_state  <= ST_F_REQ;
                    end
                end
                ST_N_ACK: begin
                    r_nptr  <= f_next(r_nowner);
                    r_state <= ST_N_SVC;
                end
                ST_N_SVC: begin
                    if (isr_done) begin
                        r_enable <= '0;
                        r_vector <= '0;
                        r_busy   <= 1'b0;
                        r_state  <= ST_IDLE;
                    end else if (w_fany) begin
                        r_nested <= 1'b1;
                        r_fowner <= w_fidx;
                        r_fintr  <= 1'b1;
                        r_enable <= '0;
                        r_vector <= '0;
                        r_busy   <= 1'b0;
                        r_state  <= ST_F_REQ;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign fintr   = r_fintr;
    assign intr    = r_intr;
    assign int_ack = r_int_ack;
    assign Enable  = r_enable;
    assign vector  = r_vector;
    assign busy    = r_busy;

endmodule

// File: tb/tb_intr_arbiter.sv
// Bench for intr_arbiter: directed scenarios with literal expectations plus
// randomized traffic, all checked every cycle against a pending/stack model.
module tb_intr_arbiter;

    logic       Clk = 1'b0;
    logic       Reset_ = 1'b1;
    logic [3:0] fintr_req = '0;
    logic [3:0] intr_req = '0;
    logic       cpu_ack = 1'b0;
    logic       isr_done = 1'b0;
    logic       fintr, intr, busy;
    logic [3:0] int_ack, Enable;
    logic [4:0] vector;

    intr_arbiter #(.N_IO(4), .IDW(4)) dut (
        .Clk(Clk), .Reset_(Reset_), .fintr_req(fintr_req), .intr_req(intr_req),
        .cpu_ack(cpu_ack), .isr_done(isr_done), .fintr(fintr), .intr(intr),
        .int_ack(int_ack), .Enable(Enable), .vector(vector), .busy(busy)
    );

    always #5 Clk = ~Clk;

    int n_vec = 0;
    int n_err = 0;

    // Model: one presented request, an ack-cycle flag, and a stack of
    // services in progress (a preempted normal service sits below a fast one).
    typedef struct packed { logic cls; logic [3:0] own; } ent_t;
    ent_t       stk[$];
    logic       m_req_v, m_req_cls, m_ack;
    logic [3:0] m_req_own;
    int         m_ptr[2];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic int rr(input logic [3:0] req, input int ptr);
        int i;
        for (int k = 0; k < 4; k++) begin
            i = (ptr + k) % 4;
            if (req[i]) return i;
        end
        return 0;
    endfunction

    task automatic model_reset();
        stk.delete();
        m_req_v = 0; m_req_cls = 0; m_req_own = 0; m_ack = 0;
        m_ptr[0] = 0; m_ptr[1] = 0;
    endtask

    task automatic model_edge();
        ent_t e;
        if (m_ack) begin
            m_ack = 0;
            e = stk[$];
            m_ptr[e.cls] = (int'(e.own) + 1) % 4;
        end else if (m_req_v) begin
            if (cpu_ack) begin
                e.cls = m_req_cls; e.own = m_req_own;
                stk.push_back(e);
                m_req_v = 0; m_ack = 1;
            end else if (!m_req_cls && |fintr_req) begin
                m_req_cls = 1; m_req_own = 4'(rr(fintr_req, m_ptr[1]));
            end
        end else if (stk.size() > 0) begin
            if (isr_done) void'(stk.pop_back());
            else if (!stk[$].cls && |fintr_req) begin
                m_req_v = 1; m_req_cls = 1; m_req_own = 4'(rr(fintr_req, m_ptr[1]));
            end
        end else if (|fintr_req) begin
            m_req_v = 1; m_req_cls = 1; m_req_own = 4'(rr(fintr_req, m_ptr[1]));
        end else if (|intr_req) begin
            m_req_v = 1; m_req_cls = 0; m_req_own = 4'(rr(intr_req, m_ptr[0]));
        end
    endtask

    task automatic compare_model();
        logic svc;
        logic [3:0] top_oh;
        svc = !m_req_v && (stk.size() > 0);
        top_oh = (stk.size() > 0) ? (4'b0001 << stk[$].own) : 4'b0000;
        chk("fintr", 32'(fintr), 32'(m_req_v && m_req_cls));
        chk("intr", 32'(intr), 32'(m_req_v && !m_req_cls));
        chk("busy", 32'(busy), 32'(svc));
        chk("Enable", 32'(Enable), svc ? 32'(top_oh) : 32'h0);
        chk("int_ack", 32'(int_ack), m_ack ? 32'(top_oh) : 32'h0);
        if (svc) chk("vector", 32'(vector), 32'({stk[$].cls, stk[$].own}));
    endtask

    task automatic step();
        @(posedge Clk);
        model_edge();
        #1;
        compare_model();
    endtask

    task automatic cyc(input logic ca, input logic id);
        cpu_ack = ca; isr_done = id;
        step();
        cpu_ack = 0; isr_done = 0;
    endtask

    task automatic do_reset();
        fintr_req = '0; intr_req = '0; cpu_ack = 0; isr_done = 0;
        #2 Reset_ = 1'b0;
        model_reset();
        #4 Reset_ = 1'b1;
    endtask

    logic [3:0] rr_exp[3];

    initial begin
        model_reset();
        #1 Reset_ = 1'b0;
        #1;
        chk("rst_fintr", 32'(fintr), 32'h0);
        chk("rst_intr", 32'(intr), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_enable", 32'(Enable), 32'h0);
        chk("rst_vector", 32'(vector), 32'h0);
        #6 Reset_ = 1'b1;

        // Fast arbitration with rotating pointer.
        fintr_req = 4'b0110;
        cyc(0, 0); chk("fa_fintr", 32'(fintr), 32'h1);
        cyc(1, 0); chk("fa_ack1", 32'(int_ack), 32'h2); chk("fa_vec1", 32'(vector), 32'h11);
        cyc(0, 0); cyc(0, 1);
        cyc(0, 0); cyc(1, 0); chk("fa_ack2", 32'(int_ack), 32'h4);
        fintr_req = 4'b0000;
        cyc(0, 0); cyc(0, 1);

        // Nested preemption of a normal service.
        do_reset();
        intr_req = 4'b0001;
        cyc(0, 0); intr_req = 4'b0000;
        cyc(1, 0); chk("np_nack", 32'(int_ack), 32'h1);
        cyc(0, 0); chk("np_en_n", 32'(Enable), 32'h1);
        fintr_req = 4'b1000;
        cyc(0, 0); chk("np_en_freq", 32'(Enable), 32'h0); chk("np_fintr", 32'(fintr), 32'h1);
        fintr_req = 4'b0000;
        cyc(1, 0); chk("np_fack", 32'(int_ack), 32'h8);
        cyc(0, 0); chk("np_en_f", 32'(Enable), 32'h8);
        cyc(0, 1); chk("np_en_back", 32'(Enable), 32'h1); chk("np_noack", 32'(int_ack), 32'h0);
        cyc(0, 1); chk("np_idle", 32'(busy), 32'h0);

        // Fast preempts a normal request before it is acknowledged.
        do_reset();
        intr_req = 4'b0001;
        cyc(0, 0); chk("pb_intr", 32'(intr), 32'h1);
        fintr_req = 4'b0100;
        cyc(0, 0); chk("pb_intr0", 32'(intr), 32'h0); chk("pb_fintr1", 32'(fintr), 32'h1);
        fintr_req = 4'b0000; intr_req = 4'b0000;
        cyc(1, 0); chk("pb_ack", 32'(int_ack), 32'h4);
        cyc(0, 0); cyc(0, 1);

        // isr_done beats a fast request in N_SVC; no nesting results.
        do_reset();
        intr_req = 4'b0001;
        cyc(0, 0); intr_req = 4'b0000;
        cyc(1, 0); cyc(0, 0);
        fintr_req = 4'b0010;
        cyc(0, 1); chk("se_idle_busy", 32'(busy), 32'h0); chk("se_idle_fintr", 32'(fintr), 32'h0);
        cyc(0, 0); chk("se_fintr", 32'(fintr), 32'h1);
        fintr_req = 4'b0000;
        cyc(1, 0); chk("se_ack", 32'(int_ack), 32'h2);
        cyc(0, 0); cyc(0, 1); chk("se_not_nested", 32'(busy), 32'h0);

        // Normal round-robin wrap.
        do_reset();
        rr_exp[0] = 4'b0001; rr_exp[1] = 4'b1000; rr_exp[2] = 4'b0001;
        intr_req = 4'b1001;
        for (int s = 0; s < 3; s++) begin
            cyc(0, 0);
            cyc(1, 0); chk("rr_ack", 32'(int_ack), 32'(rr_exp[s]));
            cyc(0, 0); cyc(0, 1);
        end
        intr_req = 4'b0000;

        // Reset during F_SVC drops outputs without a clock; pointers restart.
        fintr_req = 4'b0001;
        cyc(0, 0); fintr_req = 4'b0000;
        cyc(1, 0); cyc(0, 0); chk("rm_en_pre", 32'(Enable), 32'h1);
        #2 Reset_ = 1'b0;
        #1;
        chk("rm_en", 32'(Enable), 32'h0);
        chk("rm_fintr", 32'(fintr), 32'h0);
        chk("rm_busy", 32'(busy), 32'h0);
        model_reset();
        #3 Reset_ = 1'b1;
        intr_req = 4'b1111;
        cyc(0, 0); intr_req = 4'b0000;
        cyc(1, 0); chk("rm_first_norm", 32'(int_ack), 32'h1);
        cyc(0, 0); cyc(0, 1);

        // Randomized traffic.
        for (int c = 0; c < 4000; c++) begin
            fintr_req = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
            intr_req  = ($urandom_range(0, 1) == 0) ? 4'($urandom) : 4'b0000;
            cpu_ack   = ($urandom_range(0, 2) == 0);
            isr_done  = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 599) == 0) do_reset();
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/intr_arbiter.md
# intr_arbiter

Interrupt controller that shares the CPU's two interrupt inputs (fast and normal) among N memory-mapped IO modules. Each IO module raises level requests (`fintr_check`, `intr_check`). The arbiter picks one winner per class by round-robin, presents the request to the CPU, and pulses that module's `int_ack` when the CPU accepts. It then drives that module's `Enable` for the whole service routine. A fast interrupt may preempt a normal service routine, one nesting level deep.

## Interface
Parameters:
- `N_IO`, 4: number of IO modules, 2..16.
- `IDW`, 4: width of the index field in `vector`; must satisfy 2^IDW >= N_IO.

Ports:
- `Clk`, in, 1: system clock. All state changes on the rising edge.
- `Reset_`, in, 1: asynchronous, active-low reset.
- `fintr_req`, in, N_IO: fast request level from each IO module's `fintr_check`.
- `intr_req`, in, N_IO: normal request level from each IO module's `intr_check`.
- `cpu_ack`, in, 1: one-cycle pulse; the CPU accepts the interrupt currently presented.
- `isr_done`, in, 1: one-cycle pulse; the CPU has executed return-from-interrupt.
- `fintr`, out, 1: fast interrupt request to the CPU.
- `intr`, out, 1: normal interrupt request to the CPU.
- `int_ack`, out, N_IO: one-hot, one-cycle acknowledge to the winning IO module.
- `Enable`, out, N_IO: one-hot (or all zero) IO enable for the module being serviced.
- `vector`, out, IDW+1: {class (1 = fast), index} of the owner; valid when `busy` = 1.
- `busy`, out, 1: high in ACK and SVC states.

## Operation
States: IDLE, F_REQ, F_ACK, F_SVC, N_REQ, N_ACK, N_SVC. A `nested` flag records a preempted normal service.

- **IDLE**
  - If any `fintr_req` is set: latch the fast round-robin winner into `fowner` and go to F_REQ.
  - Otherwise, if any `intr_req` is set: latch the normal winner into `nowner` and go to N_REQ.
- **F_REQ**: `fintr` = 1. On `cpu_ack`, go to F_ACK.
- **F_ACK** (1 cycle)
  - `int_ack[fowner]` = 1 and `Enable[fowner]` = 1.
  - Fast pointer becomes `fowner+1` mod N_IO.
  - Go to F_SVC.
- **F_SVC**: `Enable[fowner]` = 1. Fast requests are not nested.
  - On `isr_done` with `nested` = 1: clear `nested` and go to N_SVC. `nowner` is unchanged.
  - On `isr_done` with `nested` = 0: go to IDLE.
- **N_REQ**: `intr` = 1.
  - On `cpu_ack`, go to N_ACK.
  - Otherwise, if any `fintr_req` is set: abandon the normal request and go to F_REQ with a new `fowner`. `intr` drops the same cycle `fintr` rises; the IO still holds its request, so it is re-arbitrated later.
- **N_ACK** (1 cycle)
  - `int_ack[nowner]` = 1 and `Enable[nowner]` = 1.
  - Normal pointer becomes `nowner+1` mod N_IO.
  - Go to N_SVC.
- **N_SVC**: `Enable[nowner]` = 1.
  - On `isr_done`, go to IDLE.
  - Otherwise, if any `fintr_req` is set: set `nested`, latch `fowner`, and go to F_REQ. `Enable` drops to zero during F_REQ.
- **Round-robin**: the search starts at the pointer index and wraps modulo N_IO. Both pointers reset to 0.
- **Ignored inputs**: `cpu_ack` outside REQ states and `isr_done` outside SVC states have no effect.

## Timing
- **Reset values**: all outputs 0, state IDLE, `nested` = 0, pointers 0. Asserting reset mid-service aborts immediately; `Enable` and `int_ack` drop asynchronously.
- **Request latency**: a request sampled in IDLE gives `fintr`/`intr` high on the next cycle.
- **Acknowledge latency**: `cpu_ack` in a REQ state gives `int_ack` exactly 1 cycle later.
- **Winner stability**: the winner is frozen on entering a REQ state. A later higher-priority-index request does not change it. Exception: a fast request during N_REQ preempts, as above.
- **Simultaneous events**
  - `isr_done` and `fintr_req` in the same N_SVC cycle: `isr_done` wins, go to IDLE; the fast request is taken from IDLE the following cycle.
  - `cpu_ack` and `fintr_req` in the same N_REQ cycle: `cpu_ack` wins, go to N_ACK.
- **Requester withdrawal**: if the requester drops its request during REQ, the arbiter still completes the ack; the CPU owns recovery.
- **Invariants**: `fintr` and `intr` are never high together. `int_ack` and `Enable` are at most one-hot.

## Structure
- **Shared package `intr_pkg`**:
  - State enum encoding.
  - Class encoding constants `CLS_FAST` = 1 and `CLS_NORM` = 0.
  - Default `N_IO`.
- **Sub-module `rr_pick`**: parameterised round-robin selector, instantiated twice (fast and normal).
  - Inputs: `req[N_IO]` and `ptr`.
  - Outputs: `any` and `idx`.
  - Purely combinational.

## Test plan
- **Fast arbitration**: N_IO = 4, `fintr_req` = 4'b0110 held. Cycle 1 `cpu_ack`, later `isr_done`, then repeat. Required: first `int_ack` = 4'b0010, `vector` = 5'b10001; second `int_ack` = 4'b0100.
- **Nested preemption**: normal on IO0 in N_SVC, then `fintr_req[3]` rises. Required: `Enable` goes 0001 -> 0000 during F_REQ -> 1000 in F_SVC. After `isr_done`, `Enable` = 0001 again in N_SVC with no second `int_ack[0]`.
- **Preempt before ack**: `intr_req` = 0001, then `fintr_req` = 0100 during N_REQ before `cpu_ack`. Required: `intr` falls, `fintr` rises the same cycle, and the ack goes to IO2.
- **Simultaneous events**: `isr_done` and `fintr_req[1]` in the same N_SVC cycle. Required: IDLE for one cycle, then `fintr` = 1, and `nested` stays 0.
- **Reset mid-service**: `Reset_` asserted low in F_SVC. Required: `Enable`, `fintr` and `busy` go to 0 without waiting for `Clk`. After release, the first normal winner is index 0.
- **Round-robin wrap**: `intr_req` = 4'b1001 held across three services. Required: acks to IO0, IO3, IO0.
